// File: rtl/imem_boot_ctrl.sv
// -----------------------------------------------------------------------------
// imem_boot_ctrl
//
// Purpose:
//   Arbitrates the single-port instruction memory of the RISC-V core between
//   two owners. After reset the loader owns the memory (BOOT). Loader words are
//   written to consecutive word addresses starting at 0. When the final word
//   arrives, or the memory is full, ownership passes to the fetch unit (RUN).
//   A reload pulse returns ownership to the loader at any time and restarts the
//   load count. Memory contents are never cleared.
//
// Build option:
//   IMEM_BOUNDS_CHECK_EN
//     Defined   : a RUN fetch whose word index is >= DEPTH is granted but does
//                 not touch the memory. It returns a NOP (addi x0,x0,0) with
//                 fe_fault high for that one response cycle.
//     Undefined : the fetch word index wraps modulo 2**AW and fe_fault is 0.
//
// Parameters:
//   DEPTH : number of 32-bit words in the memory (DEPTH <= 2**AW)
//   AW    : memory word-address width
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   ld_valid/ld_data   loader word handshake (input side)
//   ld_last            final word of the program, qualified by ld_valid
//   ld_ready           loader word accepted this cycle
//   reload             single-cycle pulse that restarts the boot load
//   fe_req/fe_addr     fetch request and byte address (bits [1:0] ignored)
//   fe_gnt             fetch accepted this cycle
//   fe_rvalid/fe_rdata read response, one cycle after fe_gnt; rdata 0 otherwise
//   fe_fault           out-of-range fetch response (bounds-check build only)
//   boot_done          high while the fetch unit owns the memory
//   ld_count           words written since the last reset or reload
//   mem_*              single-port synchronous memory interface
// -----------------------------------------------------------------------------
module imem_boot_ctrl #(
   parameter int DEPTH = 8192,
   parameter int AW    = 13
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ld_valid,
   input  logic [31:0]   ld_data,
   input  logic          ld_last,
   output logic          ld_ready,
   input  logic          reload,
   input  logic          fe_req,
   input  logic [31:0]   fe_addr,
   output logic          fe_gnt,
   output logic          fe_rvalid,
   output logic [31:0]   fe_rdata,
   output logic          fe_fault,
   output logic          boot_done,
   output logic [AW:0]   ld_count,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   typedef enum logic [0:0] {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   // DEPTH is compared against the AW+1 bit count, which can hold DEPTH itself.
   localparam logic [AW:0]  DEPTH_W  = (AW+1)'(DEPTH);
   localparam logic [AW:0]  COUNT_1  = (AW+1)'(1);
   localparam logic [31:0]  NOP_INSN = 32'h0000_0013;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [AW:0] ld_count_r;
   logic [AW:0] ld_count_nxt_s;
   logic        rvalid_r;
   logic        rvalid_nxt_s;
   logic        unused_addr_s;

   // Word index of a fetch byte address, truncated to the memory width.
   function automatic logic [AW-1:0] fetch_index(input logic [31:0] byte_addr);
      return byte_addr[AW+1:2];
   endfunction

`ifdef IMEM_BOUNDS_CHECK_EN
   localparam logic [29:0] DEPTH_IDX = 30'(DEPTH);

   logic fault_r;
   logic fault_nxt_s;
   logic oob_s;

   // The full 30-bit word index is checked, so no alias of a valid word can hit.
   assign oob_s         = (fe_addr[31:2] >= DEPTH_IDX);
   assign unused_addr_s = ^fe_addr[1:0];
`else
   assign unused_addr_s = ^{fe_addr[31:AW+2], fe_addr[1:0]};
`endif

   // Next-state, next-count and memory-port steering for the current owner.
   always_comb begin
      state_nxt_s    = state_r;
      ld_count_nxt_s = ld_count_r;
      rvalid_nxt_s   = 1'b0;
`ifdef IMEM_BOUNDS_CHECK_EN
      fault_nxt_s    = 1'b0;
`endif
      ld_ready       = 1'b0;
      fe_gnt         = 1'b0;
      mem_en         = 1'b0;
      mem_we         = 1'b0;
      mem_addr       = {AW{1'b0}};
      mem_wdata      = 32'h0000_0000;

      if (reload) begin
         // Reload cycle: neither owner gets the memory.
         state_nxt_s    = BOOT;
         ld_count_nxt_s = {(AW+1){1'b0}};
      end else begin
         case (state_r)
            BOOT: begin
               ld_ready = (ld_count_r < DEPTH_W);
               if (ld_valid && ld_ready) begin
                  mem_en         = 1'b1;
                  mem_we         = 1'b1;
                  mem_addr       = ld_count_r[AW-1:0];
                  mem_wdata      = ld_data;
                  ld_count_nxt_s = ld_count_r + COUNT_1;
                  // Leave BOOT on the last word or when this word fills memory.
                  if (ld_last || (ld_count_nxt_s == DEPTH_W)) begin
                     state_nxt_s = RUN;
                  end else begin
                     state_nxt_s = BOOT;
                  end
               end else begin
                  state_nxt_s = BOOT;
               end
            end
            RUN: begin
               fe_gnt = fe_req;
               if (fe_req) begin
                  rvalid_nxt_s = 1'b1;
`ifdef IMEM_BOUNDS_CHECK_EN
                  if (oob_s) begin
                     fault_nxt_s = 1'b1;
                  end else begin
                     mem_en   = 1'b1;
                     mem_addr = fetch_index(fe_addr);
                  end
`else
                  mem_en   = 1'b1;
                  mem_addr = fetch_index(fe_addr);
`endif
               end else begin
                  rvalid_nxt_s = 1'b0;
               end
            end
            default: begin
               state_nxt_s    = BOOT;
               ld_count_nxt_s = {(AW+1){1'b0}};
            end
         endcase
      end
   end

   // State, load count and read-response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= BOOT;
         ld_count_r <= {(AW+1){1'b0}};
         rvalid_r   <= 1'b0;
`ifdef IMEM_BOUNDS_CHECK_EN
         fault_r    <= 1'b0;
`endif
      end else begin
         state_r    <= state_nxt_s;
         ld_count_r <= ld_count_nxt_s;
         rvalid_r   <= rvalid_nxt_s;
`ifdef IMEM_BOUNDS_CHECK_EN
         fault_r    <= fault_nxt_s;
`endif
      end
   end

   // Read data is forced to 0 outside a response so stale bus values never leak.
   always_comb begin
      if (rvalid_r) begin
`ifdef IMEM_BOUNDS_CHECK_EN
         if (fault_r) begin
            fe_rdata = NOP_INSN;
         end else begin
            fe_rdata = mem_rdata;
         end
`else
         fe_rdata = mem_rdata;
`endif
      end else begin
         fe_rdata = 32'h0000_0000;
      end
   end

   assign fe_rvalid = rvalid_r;
   assign boot_done = (state_r == RUN);
   assign ld_count  = ld_count_r;
`ifdef IMEM_BOUNDS_CHECK_EN
   assign fe_fault  = fault_r;
`else
   assign fe_fault  = 1'b0;
`endif

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_ctrl
//
// Directed scenarios followed by randomized traffic. A transaction-level model
// (owner flag, word count, expected memory image, pending read response)
// predicts every DUT output each cycle. The memory behind the DUT is a simple
// synchronous array driven only by the DUT's memory port.
// A small DEPTH is used so that the fill-to-capacity path is reachable.
// -----------------------------------------------------------------------------
module tb_imem_boot_ctrl;

   localparam int          DEPTH = 8;
   localparam int          AW    = 13;
   localparam int          MSIZE = 1 << AW;
   localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IMEM_BOUNDS_CHECK_EN
   localparam bit          BCHK  = 1'b1;
`else
   localparam bit          BCHK  = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          ld_valid;
   logic [31:0]   ld_data;
   logic          ld_last;
   logic          ld_ready;
   logic          reload;
   logic          fe_req;
   logic [31:0]   fe_addr;
   logic          fe_gnt;
   logic          fe_rvalid;
   logic [31:0]   fe_rdata;
   logic          fe_fault;
   logic          boot_done;
   logic [AW:0]   ld_count;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   imem_boot_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .ld_valid  (ld_valid),
      .ld_data   (ld_data),
      .ld_last   (ld_last),
      .ld_ready  (ld_ready),
      .reload    (reload),
      .fe_req    (fe_req),
      .fe_addr   (fe_addr),
      .fe_gnt    (fe_gnt),
      .fe_rvalid (fe_rvalid),
      .fe_rdata  (fe_rdata),
      .fe_fault  (fe_fault),
      .boot_done (boot_done),
      .ld_count  (ld_count),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model state
   bit          m_run;
   int          m_count;
   bit          m_rv;
   bit          m_fault;
   logic [31:0] m_rdata;
   logic [31:0] ref_mem  [0:MSIZE-1];
   logic [31:0] phys_mem [0:MSIZE-1];

   // last observed DUT values (sampled mid-cycle)
   logic          o_ready, o_gnt, o_en, o_we, o_rvalid, o_fault, o_done;
   logic [AW-1:0] o_addr;
   logic [31:0]   o_wdata, o_rdata;
   logic [AW:0]   o_count;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // One clock cycle: drive inputs, check predictions, advance memory and model.
   task automatic cycle(input bit i_rst, input bit i_rel, input bit i_ldv,
                        input logic [31:0] i_ldd, input bit i_last,
                        input bit i_req, input logic [31:0] i_addr);
      bit            e_ready, e_gnt, e_en, e_we, e_oob;
      logic [AW-1:0] e_addr;
      logic [31:0]   e_wdata;
      int unsigned   idx;
      @(negedge clk);
      rst = i_rst; reload = i_rel; ld_valid = i_ldv; ld_data = i_ldd;
      ld_last = i_last; fe_req = i_req; fe_addr = i_addr;
      #1;
      e_ready = 1'b0; e_gnt = 1'b0; e_en = 1'b0; e_we = 1'b0; e_oob = 1'b0;
      e_addr = '0; e_wdata = 32'h0;
      idx = i_addr >> 2;
      if (!i_rel) begin
         if (!m_run) begin
            e_ready = (m_count < DEPTH);
            if (i_ldv && e_ready) begin
               e_en = 1'b1; e_we = 1'b1; e_addr = AW'(m_count); e_wdata = i_ldd;
            end
         end else begin
            e_gnt = i_req;
            if (i_req) begin
               if (BCHK && idx >= DEPTH) e_oob = 1'b1;
               else begin e_en = 1'b1; e_addr = AW'(idx % MSIZE); end
            end
         end
      end
      chk("boot_done", boot_done, m_run);
      chk("ld_count",  ld_count,  m_count);
      chk("fe_rvalid", fe_rvalid, m_rv);
      chk("fe_fault",  fe_fault,  m_fault);
      chk("fe_rdata",  fe_rdata,  m_rv ? m_rdata : 32'h0);
      chk("ld_ready",  ld_ready,  e_ready);
      chk("fe_gnt",    fe_gnt,    e_gnt);
      chk("mem_en",    mem_en,    e_en);
      chk("mem_we",    mem_we,    e_we);
      chk("mem_addr",  mem_addr,  e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      o_ready = ld_ready; o_gnt = fe_gnt; o_en = mem_en; o_we = mem_we;
      o_addr = mem_addr; o_wdata = mem_wdata; o_rvalid = fe_rvalid;
      o_rdata = fe_rdata; o_fault = fe_fault; o_done = boot_done; o_count = ld_count;
      @(posedge clk);
      #1;
      // memory behind the DUT reacts to what the DUT actually drove
      if (o_en && o_we) phys_mem[o_addr] = o_wdata;
      mem_rdata = (o_en && !o_we) ? phys_mem[o_addr] : $urandom;
      // model advance
      m_rv    = e_gnt;
      m_fault = e_oob;
      m_rdata = e_oob ? NOP : ref_mem[idx % MSIZE];
      if (e_en && e_we) begin
         ref_mem[m_count] = i_ldd;
         m_count++;
         if (i_last || m_count == DEPTH) m_run = 1'b1;
      end
      if (i_rel) begin m_run = 1'b0; m_count = 0; end
      if (i_rst) begin m_run = 1'b0; m_count = 0; m_rv = 1'b0; m_fault = 1'b0; end
   endtask

   logic [31:0] prog [0:3];

   initial begin
      prog[0] = 32'h0050_0093; prog[1] = 32'h0010_0113;
      prog[2] = 32'h0020_81B3; prog[3] = 32'h0000_006F;
      for (int i = 0; i < MSIZE; i++) begin ref_mem[i] = 32'h0; phys_mem[i] = 32'h0; end
      rst = 1'b1; reload = 1'b0; ld_valid = 1'b0; ld_data = 32'h0; ld_last = 1'b0;
      fe_req = 1'b0; fe_addr = 32'h0; mem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      m_run = 1'b0; m_count = 0; m_rv = 1'b0; m_fault = 1'b0; m_rdata = 32'h0;
      @(negedge clk);
      chk("rst_ld_count",  ld_count,  '0);
      chk("rst_boot_done", boot_done, 1'b0);
      chk("rst_rvalid",    fe_rvalid, 1'b0);
      chk("rst_fault",     fe_fault,  1'b0);

      // 1: four-word boot load, fetch requests held high must be ignored
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b0, 1'b1, prog[i], (i == 3), 1'b1, 32'h0);
         chk("t1_addr", o_addr, i);
         chk("t1_gnt",  o_gnt,  1'b0);
      end
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("t1_count", o_count, 4);
      chk("t1_done",  o_done,  1'b1);

      // 2: back-to-back fetches
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0008);
      chk("t2_gnt0",  o_gnt,  1'b1);
      chk("t2_addr0", o_addr, 2);
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_000C);
      chk("t2_gnt1",  o_gnt,  1'b1);
      chk("t2_addr1", o_addr, 3);
      chk("t2_rv0",   o_rvalid, 1'b1);
      chk("t2_data0", o_rdata, 32'h0020_81B3);
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("t2_rv1",   o_rvalid, 1'b1);
      chk("t2_data1", o_rdata, 32'h0000_006F);

      // 4: reload in the cycle after a grant
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0000);
      cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0004);
      chk("t4_rv",    o_rvalid, 1'b1);
      chk("t4_gnt",   o_gnt,    1'b0);
      chk("t4_ready", o_ready,  1'b0);
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0004);
      chk("t4_gnt2",  o_gnt,   1'b0);
      chk("t4_count", o_count, 0);
      chk("t4_done",  o_done,  1'b0);

      // 5: reset mid-load, then a fresh three-word load
      for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1, $urandom, 1'b0, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("t5_count", o_count, 0);
      chk("t5_done",  o_done,  1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, 1'b1, $urandom, (i == 2), 1'b0, 32'h0);
         chk("t5_addr", o_addr, i);
      end

      // 6: fetch far beyond DEPTH
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_8000);
      chk("t6_gnt",  o_gnt,  1'b1);
      chk("t6_en",   o_en,   !BCHK);
      chk("t6_addr", o_addr, 0);
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("t6_rv",    o_rvalid, 1'b1);
      chk("t6_fault", o_fault,  BCHK);
      chk("t6_data",  o_rdata,  BCHK ? NOP : ref_mem[0]);
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("t6_fault_end", o_fault, 1'b0);

      // 3: fill to capacity without ld_last
      cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i <= DEPTH; i++) begin
         cycle(1'b0, 1'b0, 1'b1, $urandom, 1'b0, 1'b0, 32'h0);
         chk("t3_ready", o_ready, (i < DEPTH));
         chk("t3_write", o_en,    (i < DEPTH));
      end
      chk("t3_count", o_count, DEPTH);
      chk("t3_done",  o_done,  1'b1);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         bit          r_rst, r_rel, r_ldv, r_last, r_req;
         logic [31:0] r_addr;
         int unsigned sel;
         r_rst  = ($urandom_range(0, 199) == 0);
         r_rel  = ($urandom_range(0, 39) == 0);
         r_ldv  = ($urandom_range(0, 9) < 7);
         r_last = ($urandom_range(0, 9) == 0);
         r_req  = ($urandom_range(0, 9) < 7);
         sel    = $urandom_range(0, 9);
         if (sel < 7)       r_addr = ($urandom_range(0, DEPTH - 1) << 2);
         else if (sel == 7) r_addr = ($urandom_range(DEPTH, MSIZE - 1) << 2);
         else if (sel == 8) r_addr = $urandom;
         else               r_addr = (($urandom_range(0, DEPTH - 1) + MSIZE) << 2);
         r_addr[1:0] = 2'($urandom);
         cycle(r_rst, r_rel, r_ldv, $urandom, r_last, r_req, r_addr);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
Controller for the single-port instruction memory of the RISC-V core. After reset it sequences a boot load: words stream in from a loader interface (UART/debug) and are written to consecutive addresses from 0. Once the load completes, it grants the memory to the core's fetch unit. A reload request returns the memory to the loader at any time.

Parameters:
DEPTH, 8192, number of 32-bit instruction words; must satisfy DEPTH <= 2**AW.
AW, 13, memory word-address width.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
ld_valid  in  1  loader word available
ld_data  in  32  loader instruction word
ld_last  in  1  marks the final word of the program; qualified by ld_valid
ld_ready  out  1  controller accepts a loader word this cycle
reload  in  1  single-cycle pulse; restart the boot load
fe_req  in  1  fetch read request
fe_addr  in  32  fetch byte address; bits [1:0] ignored
fe_gnt  out  1  fetch request accepted this cycle
fe_rvalid  out  1  read data valid; one cycle after fe_gnt
fe_rdata  out  32  fetched word; 0 when fe_rvalid=0
fe_fault  out  1  out-of-range fetch; only with optional feature
boot_done  out  1  high in RUN state
ld_count  out  AW+1  words written since last reset or reload
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  AW  memory word address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, synchronous, valid the cycle after mem_en&!mem_we

Behaviour:
- Reset values (rst=1 at a clock edge): state=BOOT, ld_count=0, fe_rvalid=0, fe_fault=0, boot_done=0. Combinational outputs evaluate from the reset state.
- States:
  - BOOT: loader owns the memory.
  - RUN: fetch owns the memory.
- BOOT:
  - ld_ready = (ld_count < DEPTH). fe_gnt = 0.
  - On ld_valid&ld_ready: mem_en=1, mem_we=1, mem_addr=ld_count[AW-1:0], mem_wdata=ld_data; ld_count increments next edge.
  - Go to RUN next edge when either the accepted word has ld_last=1, or the accepted word brings ld_count to DEPTH.
  - ld_valid with ld_ready=0 is ignored and causes no write.
- RUN:
  - ld_ready=0, boot_done=1.
  - fe_gnt = fe_req, same cycle. On grant: mem_en=1, mem_we=0, mem_addr=fe_addr[AW+1:2].
  - fe_rvalid registered: high exactly one cycle after each grant. fe_rdata = mem_rdata while fe_rvalid=1.
  - Back-to-back grants give back-to-back rvalid; throughput is 1 word/cycle.
- No access: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- reload=1 in either state:
  - Next edge: state=BOOT, ld_count=0, boot_done=0.
  - In the reload cycle itself: no loader write and no new fetch grant (fe_gnt=0, ld_ready=0).
  - A read granted in the previous cycle still produces its fe_rvalid.
- reload and rst together: rst wins (identical end state).
- A reset or reload during BOOT discards the partial load count. Memory contents are not cleared.
- ld_count saturates at DEPTH; no wrap.

Optional Feature:
Macro IMEM_BOUNDS_CHECK_EN.
- Defined: in RUN, a fetch with word index fe_addr[31:2] >= DEPTH is still granted (fe_gnt=1) but mem_en stays 0. Next cycle: fe_rvalid=1, fe_rdata=32'h00000013 (NOP), fe_fault=1 for that cycle only.
- Not defined: the address is truncated to AW bits (wraps modulo 2**AW), and fe_fault is tied to 0.

Test Plan:
1. Reset, then stream 4 words 0x00500093, 0x00100113, 0x002081B3, 0x0000006F with ld_last on the 4th -> writes go to mem_addr 0..3, ld_count=4, boot_done=1 the cycle after the 4th accept, fe_gnt=0 throughout BOOT.
2. RUN, fe_req with fe_addr=0x8, then 0xC on consecutive cycles -> fe_gnt=1 both cycles, mem_addr=2 then 3, fe_rvalid high on the 2 following cycles with fe_rdata 0x002081B3 then 0x0000006F.
3. With DEPTH=4, stream 5 words with no ld_last -> 4 writes, ld_ready drops after the 4th, the 5th word is not written, RUN entered.
4. reload pulsed in the cycle after a fetch grant -> fe_rvalid still asserted that cycle, next cycle state=BOOT, ld_count=0, boot_done=0, fe_req ignored (fe_gnt=0).
5. rst asserted after 2 of 4 loader words -> ld_count=0, state BOOT; a fresh 3-word load then writes addresses 0..2.
6. IMEM_BOUNDS_CHECK_EN defined, DEPTH=8192, fe_addr=0x8000 -> fe_gnt=1, mem_en=0, next cycle fe_rvalid=1, fe_rdata=0x00000013, fe_fault=1. Not defined -> mem_addr=0, fe_fault=0.
